// File: rtl/mem_pkg.sv
// Shared types and constants for the memory datapath stage.
package mem_pkg;
    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 15;
    localparam int WR_LAT_MAX = 15;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        DONE = 3'd3,
        VFY  = 3'd4
    } state_t;
endpackage

// File: rtl/mem_ram_sp.sv
// Single-port synchronous RAM; read data registered and only updated when re is high.
module mem_ram_sp #(
    parameter int AW = 15,
    parameter int DW = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // Array deliberately has no reset so it maps onto a RAM macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_datapath.sv
// Memory datapath stage: captures address/data, runs multi-cycle RAM writes and single reads.
// Optional MEM_DATAPATH_VERIFY_EN adds a read-back verify state and a sticky mismatch output.
module mem_datapath
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int WR_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loadA,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              loadD,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write,
    input  logic              read,
    output logic              done,
    output logic              busy,
    output logic [DATA_W-1:0] rd_data,
`ifdef MEM_DATAPATH_VERIFY_EN
    output logic              mismatch,
`endif
    output logic              err
);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rd_hold_q, rd_hold_d;
    logic              op_rd_q, op_rd_d;
    logic              err_q, err_d;
`ifdef MEM_DATAPATH_VERIFY_EN
    logic              mismatch_q, mismatch_d;
`endif

    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;
    logic              any_strobe;

    assign any_strobe = loadA | loadD | write | read;
    assign ram_we     = (state_q == WR);
    assign ram_re     = (state_q == RD) || (state_q == VFY);

    mem_ram_sp #(.AW(ADDR_W), .DW(DATA_W)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rd_hold_d = rd_hold_q;
        op_rd_d   = op_rd_q;
        err_d     = err_q;
`ifdef MEM_DATAPATH_VERIFY_EN
        mismatch_d = mismatch_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts new work directly so a strobe there is never lost.
                if (state_q == DONE) begin
                    if (op_rd_q) begin
                        rd_hold_d = ram_rdata;
                    end
`ifdef MEM_DATAPATH_VERIFY_EN
                    else if (ram_rdata != data_q) begin
                        mismatch_d = 1'b1;
                    end
`endif
                end
                if (loadA) addr_d = addr_in;
                if (loadD) data_d = data_in;
                if (write) begin
                    state_d = WR;
                    cnt_d   = CNT_W'(WR_LAT - 1);
                    op_rd_d = 1'b0;
                end else if (read) begin
                    state_d = RD;
                    op_rd_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WR: begin
                if (any_strobe) err_d = 1'b1;
                if (cnt_q == '0) begin
`ifdef MEM_DATAPATH_VERIFY_EN
                    state_d = VFY;
`else
                    state_d = DONE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD, VFY: begin
                if (any_strobe) err_d = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_hold_q <= '0;
            op_rd_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef MEM_DATAPATH_VERIFY_EN
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_hold_q <= rd_hold_d;
            op_rd_q   <= op_rd_d;
            err_q     <= err_d;
`ifdef MEM_DATAPATH_VERIFY_EN
            mismatch_q <= mismatch_d;
`endif
        end
    end

    // Read result is visible during the done cycle itself, then held.
    assign rd_data = (state_q == DONE && op_rd_q) ? ram_rdata : rd_hold_q;
    assign done    = (state_q == DONE);
    assign busy    = (state_q == WR) || (state_q == RD) || (state_q == VFY);
    assign err     = err_q;
`ifdef MEM_DATAPATH_VERIFY_EN
    assign mismatch = mismatch_q;
`endif
endmodule

// File: tb/tb_mem_datapath.sv
// Self-checking bench for mem_datapath: directed table, corner sequences and randomized ops vs a model.
module tb_mem_datapath;
    localparam int AW = 15;
    localparam int DW = 15;
    localparam int WL = 2;
`ifdef MEM_DATAPATH_VERIFY_EN
    localparam int WLAT = WL + 2;
`else
    localparam int WLAT = WL + 1;
`endif
    localparam int RLAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          loadA, loadD, write, read;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          done, busy, err;
    logic [DW-1:0] rd_data;
`ifdef MEM_DATAPATH_VERIFY_EN
    logic          mismatch;
`endif

    mem_datapath #(.ADDR_W(AW), .DATA_W(DW), .WR_LAT(WL)) dut (
        .clk     (clk),
        .rst     (rst),
        .loadA   (loadA),
        .addr_in (addr_in),
        .loadD   (loadD),
        .data_in (data_in),
        .write   (write),
        .read    (read),
        .done    (done),
        .busy    (busy),
        .rd_data (rd_data),
`ifdef MEM_DATAPATH_VERIFY_EN
        .mismatch(mismatch),
`endif
        .err     (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [DW-1:0] model [int];
    logic [DW-1:0] last_rd;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic clear_strobes();
        loadA = 1'b0; loadD = 1'b0; write = 1'b0; read = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (lat = cycles after the strobe edge).
    task automatic op(input bit la, input logic [AW-1:0] a, input bit ld, input logic [DW-1:0] d,
                      input bit wr, input bit rd, output int lat);
        loadA = la; addr_in = a; loadD = ld; data_in = d; write = wr; read = rd;
        @(posedge clk); #1;
        clear_strobes();
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic count_dones(input int n, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done) c++;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input string nm);
        int lat;
        op(1'b1, a, 1'b1, d, 1'b1, 1'b0, lat);
        check({nm, "_wlat"}, lat, WLAT);
        model[int'(a)] = d;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
        int lat;
        op(1'b1, a, 1'b0, '0, 1'b0, 1'b1, lat);
        check({nm, "_rlat"}, lat, RLAT);
        check({nm, "_rdata"}, rd_data, exp);
        last_rd = exp;
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp;
    } vec_t;

    initial begin
        vec_t vt [5];
        int   lat, nd;
        logic [AW-1:0] cur_a, ra;
        logic [DW-1:0] cur_d, rdv;
        bit   la, ld, do_rd;

        vt[0] = '{15'h0012, 15'h5A5A, 15'h5A5A};
        vt[1] = '{15'h7FFF, 15'h7FFF, 15'h7FFF};
        vt[2] = '{15'h0000, 15'h0001, 15'h0001};
        vt[3] = '{15'h4000, 15'h2AAA, 15'h2AAA};
        vt[4] = '{15'h3FFF, 15'h1555, 15'h1555};

        rst = 1'b1; addr_in = '0; data_in = '0; clear_strobes();
        last_rd = '0;
        #2;
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_rd_data", rd_data, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Write all vectors, then read them back to expose any address aliasing.
        foreach (vt[i]) wr(vt[i].a, vt[i].d, $sformatf("tbl_w%0d", i));
        foreach (vt[i]) rd(vt[i].a, vt[i].exp, $sformatf("tbl_r%0d", i));

        // Strobe while busy: second write with new data must be ignored.
        @(negedge clk);
        loadA = 1; addr_in = 15'd5; loadD = 1; data_in = 15'h1111; write = 1;
        @(posedge clk); #1; clear_strobes();
        @(negedge clk);
        check("busy_in_wr", busy, 1);
        loadD = 1; data_in = 15'h2222; write = 1;
        @(posedge clk); #1; clear_strobes();
        count_dones(12, nd);
        check("busy_one_done", nd, 1);
        check("busy_err", err, 1);
        rd(15'd5, 15'h1111, "busy_rd5");
        op(1'b1, 15'd6, 1'b0, '0, 1'b1, 1'b0, lat);
        check("busy_data_kept_wlat", lat, WLAT);
        rd(15'd6, 15'h1111, "busy_rd6");

        // Simultaneous loadA/loadD/write/read: only the write happens.
        op(1'b1, 15'd3, 1'b1, 15'h0ABC, 1'b1, 1'b1, lat);
        check("sim_wlat", lat, WLAT);
        count_dones(6, nd);
        check("sim_no_extra_done", nd, 0);
        rd(15'd3, 15'h0ABC, "sim_rd3");

        // Reset in the middle of a write.
        loadA = 1; addr_in = 15'd7; loadD = 1; data_in = 15'h0333; write = 1;
        @(posedge clk); #1; clear_strobes();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_done", done, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_rd_data", rd_data, 0);
        count_dones(3, nd);
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
        count_dones(5, lat);
        check("mid_rst_no_done", nd + lat, 0);
        wr(15'd7, 15'h0777, "post_rst_w7");
        check("post_rst_rd_held", rd_data, last_rd);
        rd(15'd7, 15'h0777, "post_rst_r7");

        // Randomized ops against the model; register contents tracked at the level of "last loaded".
        cur_a = 15'h0100 + 15'($urandom_range(0, 15));
        cur_d = 15'($urandom);
        wr(cur_a, cur_d, "rnd_init");
        for (int i = 0; i < 150; i++) begin
            la = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 3) != 0);
            ra = 15'h0100 + 15'($urandom_range(0, 15));
            rdv = 15'($urandom);
            if (la) cur_a = ra;
            if (ld) cur_d = rdv;
            do_rd = model.exists(int'(cur_a)) && ($urandom_range(0, 1) == 1);
            op(la, ra, ld, rdv, !do_rd, do_rd, lat);
            if (do_rd) begin
                last_rd = model[int'(cur_a)];
                check($sformatf("rnd%0d_rlat", i), lat, RLAT);
                check($sformatf("rnd%0d_rdata", i), rd_data, last_rd);
            end else begin
                model[int'(cur_a)] = cur_d;
                check($sformatf("rnd%0d_wlat", i), lat, WLAT);
                check($sformatf("rnd%0d_rd_held", i), rd_data, last_rd);
            end
        end
        check("rnd_err_clear", err, 0);

`ifdef MEM_DATAPATH_VERIFY_EN
        wr(15'h0012, 15'h0F0F, "vfy_good");
        @(negedge clk);
        check("vfy_good_mismatch", mismatch, 0);
        force dut.ram_we = 1'b0;
        op(1'b1, 15'h0012, 1'b1, 15'h1234, 1'b1, 1'b0, lat);
        check("vfy_bad_wlat", lat, WLAT);
        @(negedge clk);
        release dut.ram_we;
        check("vfy_bad_mismatch", mismatch, 1);
        rd(15'h0012, 15'h0F0F, "vfy_bad_rd");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_datapath.md
Name: mem_datapath

Overview:
- Memory datapath stage that sits directly downstream of the memory-control FSM.
- Captures an address and a data word on the controller's load strobes. On a write strobe it performs a multi-cycle write into an internal synchronous RAM, then returns a one-cycle done pulse that advances the controller.
- Also supports single-word reads, so the controller's later passes can inspect memory contents.

Parameters:
- ADDR_W, 15, address width; the RAM holds 2**ADDR_W words.
- DATA_W, 15, data word width.
- WR_LAT, 2, write occupancy in cycles (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- loadA  in  1  capture addr_in into the address register.
- addr_in  in  ADDR_W  address value.
- loadD  in  1  capture data_in into the data register.
- data_in  in  DATA_W  write data value.
- write  in  1  start a write of the data register to the address register.
- read  in  1  start a read at the address register.
- done  out  1  one-cycle pulse when a write or read completes.
- busy  out  1  high while an operation is in progress.
- rd_data  out  DATA_W  read result, held until the next read completes.
- err  out  1  sticky flag: a strobe arrived while busy; cleared only by rst.

Behaviour:
- Reset (async, immediate):
  - Address register, data register, rd_data, done, busy, err all go to 0.
  - State goes to IDLE and the latency counter to 0.
  - RAM contents are not cleared.
- States: IDLE, WR, RD, DONE. Encoded via a shared enum.
- IDLE:
  - loadA=1 captures addr_in at the clock edge; loadD=1 captures data_in. Both may be asserted in the same cycle.
  - write=1 goes to WR; the counter loads WR_LAT-1.
  - read=1 (with write=0) goes to RD.
  - If write and read are both asserted, write wins and read is dropped.
  - Load strobes in the same cycle as write/read are captured first. The operation then uses the newly captured values.
- WR:
  - busy=1 and the RAM write-enable is asserted every cycle.
  - The counter decrements each cycle; at 0 the next state is DONE.
  - Total occupancy is exactly WR_LAT cycles.
- RD:
  - One cycle of synchronous RAM read.
  - rd_data updates at the end of RD; the next state is DONE.
- DONE:
  - done=1 for exactly one cycle and busy=0; the next state is IDLE.
  - A new write/read accepted in DONE is started in the following cycle. It is not lost: it is registered as pending in DONE.
- Latency, from the write-strobe edge to the done-high cycle, is WR_LAT+1 cycles. Read latency is 2 cycles.
- Any loadA, loadD, write or read while in WR or RD:
  - The strobe is ignored and err is set.
  - The registers and the operation in flight are unaffected.
- Address arithmetic: no auto-increment; the address is exactly addr_in, so full range 0..2**ADDR_W-1 and no wrap logic.
- Reset mid-operation: the operation is aborted and no done is produced. The RAM word may or may not have been written; that word is not verified after reset.

Optional Feature:
- Macro: MEM_DATAPATH_VERIFY_EN.
- Defined:
  - After WR, the block inserts an extra VFY state: one RAM read of the same address, compared against the data register.
  - Adds output mismatch (1 bit). It is a sticky flag set on a compare failure and cleared by rst.
  - Write latency becomes WR_LAT+2.
- Undefined: no VFY state, no mismatch port, latency as above.

Decomposition:
- Package mem_pkg: state enum (IDLE, WR, RD, DONE, VFY), default ADDR_W/DATA_W constants, and the WR_LAT maximum.
- One sub-module, mem_ram_sp: single-port synchronous RAM with we, addr, wdata, rdata and registered read.
- FSM, registers and counter stay in mem_datapath.

Test Plan:
- Write/read round trip: rst, then loadA with 0x0012 and loadD with 0x5A5A, then write. Expect done at cycle +3 (WR_LAT=2). Then read: done at +2 and rd_data=0x5A5A.
- Range boundaries: write 0x7FFF to address 0x7FFF and 0x0001 to address 0x0000. Reading each back returns the correct word, with no aliasing.
- Strobe while busy: write 0x1111 to address 5; during WR pulse loadD with 0x2222 and write. Expect err=1, one done only, and a read of address 5 returns 0x1111.
- Simultaneous strobes: loadA=3, loadD=0x0ABC, write and read all in the same cycle. Expect only a write to address 3 and one done; a later read returns 0x0ABC.
- Reset mid-write: assert rst during WR. All outputs go to 0 immediately and no done appears. A subsequent normal write/read to address 7 works.
- With MEM_DATAPATH_VERIFY_EN: a normal write gives done at +4 and mismatch=0. Force an RAM write-enable fault (testbench forces the enable low) and expect mismatch=1.
